// File: rtl/booth_r4_mul.sv
// booth_r4_mul: iterative radix-4 Booth multiplier, two multiplier bits per cycle,
// signed/unsigned operands, optional accumulate into dout, valid/ready on both sides.
module booth_r4_mul #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 32
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic                  acc_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int ITER = (DIN1_WIDTH + 2) / 2;
    localparam int AW = DIN0_WIDTH + 3;
    localparam int BW = 2 * ITER + 1;
    localparam int CW = $clog2(ITER + 1);

    if (DIN0_WIDTH < 2 || DIN1_WIDTH < 2 || DOUT_WIDTH < DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_params
        $error("booth_r4_mul: invalid width parameters");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                      state;
    logic signed [DIN0_WIDTH:0]  a_pos, a_neg, a_in;
    logic signed [DIN1_WIDTH:0]  b_in;
    logic signed [AW-1:0]        acc, addend, sum;
    logic [BW-1:0]               mb;
    logic [CW-1:0]               cnt;
    logic                        acc_en_q;
    logic [2:0]                  t;
    logic signed [AW+BW-1:0]     sh;
    logic signed [AW+BW-2:0]     prod;

    assign a_in = {is_signed & din0[DIN0_WIDTH-1], din0};
    assign b_in = {is_signed & din1[DIN1_WIDTH-1], din1};
    assign in_ready = state == IDLE;
    assign t = mb[2:0];
    assign addend = (t == 3'b001 || t == 3'b010) ? AW'(a_pos) :
                    (t == 3'b011)                ? AW'(a_pos) <<< 1 :
                    (t == 3'b100)                ? AW'(a_neg) <<< 1 :
                    (t == 3'b101 || t == 3'b110) ? AW'(a_neg) : '0;
    assign sum = acc + addend;
    // mb[0] is the previous multiplier bit; after the last shift it holds leftover sign, so drop it
    assign sh = $signed({sum, mb}) >>> 2;
    assign prod = sh[AW+BW-1:1];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            a_pos     <= '0;
            a_neg     <= '0;
            acc       <= '0;
            mb        <= '0;
            cnt       <= '0;
            acc_en_q  <= 1'b0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_pos    <= a_in;
                    a_neg    <= -a_in;
                    mb       <= {(BW-1)'(b_in), 1'b0};
                    acc      <= '0;
                    cnt      <= '0;
                    acc_en_q <= acc_en;
                    state    <= CALC;
                end
                CALC: begin
                    {acc, mb} <= sh;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        dout      <= (acc_en_q ? dout : '0) + DOUT_WIDTH'(prod);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: directed and randomized checks of booth_r4_mul at default widths.
module tb_booth_r4_mul;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic [15:0] din0 = '0, din1 = '0;
    logic        is_signed = 1'b0, acc_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] dout;
    logic [31:0] ref_dout = '0;
    int          checks = 0, failures = 0;

    always #5 axis_clk = ~axis_clk;

    booth_r4_mul dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .din0(din0), .din1(din1),
        .is_signed(is_signed), .acc_en(acc_en), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ae,
                      input logic [31:0] exp, input int hold, input string tag);
        int lat;
        @(negedge axis_clk);
        din0 = a; din1 = b; is_signed = s; acc_en = ae; in_valid = 1'b1;
        chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
        @(negedge axis_clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            chk({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
            din0 = 16'($urandom); din1 = 16'($urandom);
            is_signed = 1'($urandom); acc_en = 1'($urandom); out_ready = 1'($urandom);
            @(negedge axis_clk);
            lat++;
        end
        out_ready = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        repeat (hold) begin
            in_valid = 1'b1;
            din0 = 16'($urandom);
            @(negedge axis_clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_dout"}, dout, exp);
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge axis_clk);
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_dout_kept"}, dout, exp);
        ref_dout = exp;
    endtask

    initial begin
        logic [15:0]        ra, rb;
        logic               rs, rae;
        logic signed [63:0] p;
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        chk("rst_ready", 32'(in_ready), 32'd1);

        op(16'd3, 16'hFFFB, 1'b1, 1'b0, 32'hFFFF_FFF1, 0, "s_3x-5");
        op(16'h8000, 16'h8000, 1'b1, 1'b0, 32'h4000_0000, 0, "s_min_min");
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, 0, "u_max_max");
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'h0000_0001, 0, "s_m1_m1");
        op(16'h7FFF, 16'h8000, 1'b1, 1'b0, 32'hC000_8000, 0, "s_max_min");
        op(16'hFFFF, 16'h0002, 1'b0, 1'b0, 32'h0001_FFFE, 0, "u_max_2");
        op(16'd1000, 16'd1000, 1'b0, 1'b0, 32'd1000000, 0, "acc_first");
        op(16'd2000, 16'd3, 1'b0, 1'b1, 32'd1006000, 0, "acc_add");
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, 0, "wrap_base");
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFC_0002, 0, "wrap_1");
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFA_0003, 0, "wrap_2");
        op(16'h1234, 16'h0010, 1'b1, 1'b0, 32'h0001_2340, 20, "backpressure");

        // reset while the digit counter is at 4, after disturbing the operands
        @(negedge axis_clk);
        din0 = 16'd100; din1 = 16'd200; is_signed = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
        @(negedge axis_clk);
        in_valid = 1'b0;
        repeat (2) @(negedge axis_clk);
        din0 = 16'd55; din1 = 16'd66;
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_dout", dout, 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        ref_dout = '0;
        op(16'd7, 16'd6, 1'b0, 1'b0, 32'd42, 0, "after_rst");

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rae = 1'($urandom);
            if (i % 10 == 0) begin
                ra = (i % 20 == 0) ? 16'h8000 : 16'hFFFF;
                rb = 16'h8000;
            end
            if (rs) p = 64'($signed(ra)) * 64'($signed(rb));
            else p = 64'(ra) * 64'(rb);
            op(ra, rb, rs, rae, (rae ? ref_dout : 32'h0) + p[31:0], $urandom_range(0, 2), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
